// File: rtl/banderas_pkg.sv
// Shared definitions for the NZCV flag consumer: condition codes, trap FSM
// states, ALU add/sub group selector and NZCV bit positions.
package banderas_pkg;

  typedef enum logic [3:0] {
    CC_EQ  = 4'h0,
    CC_NE  = 4'h1,
    CC_CS  = 4'h2,
    CC_CC  = 4'h3,
    CC_MI  = 4'h4,
    CC_PL  = 4'h5,
    CC_VS  = 4'h6,
    CC_VC  = 4'h7,
    CC_HI  = 4'h8,
    CC_LS  = 4'h9,
    CC_GE  = 4'hA,
    CC_LT  = 4'hB,
    CC_GT  = 4'hC,
    CC_LE  = 4'hD,
    CC_AL  = 4'hE,
    CC_RSV = 4'hF
  } cond_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ESPERA = 2'd2
  } trap_st_e;

  // sel[2:1] value of the add/sub group; only these ops produce a valid V
  localparam logic [1:0] SEL_ADDSUB = 2'b00;

  localparam int IDX_N = 3;
  localparam int IDX_Z = 2;
  localparam int IDX_C = 1;
  localparam int IDX_V = 0;

endpackage

// File: rtl/banderas_cond_evaluador_cond.sv
// Purely combinational condition evaluator: NZCV flags + 4-bit condition
// field -> conditional-execute enable.
module evaluador_cond
  import banderas_pkg::*;
(
  input  logic [3:0] i_flags,
  input  logic [3:0] i_cond,
  output logic       o_ejecutar
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = i_flags[IDX_N];
  assign w_z = i_flags[IDX_Z];
  assign w_c = i_flags[IDX_C];
  assign w_v = i_flags[IDX_V];

  // Decode the condition field against the selected flags
  always_comb begin
    o_ejecutar = 1'b0;
    case (cond_e'(i_cond))
      CC_EQ:   o_ejecutar = w_z;
      CC_NE:   o_ejecutar = ~w_z;
      CC_CS:   o_ejecutar = w_c;
      CC_CC:   o_ejecutar = ~w_c;
      CC_MI:   o_ejecutar = w_n;
      CC_PL:   o_ejecutar = ~w_n;
      CC_VS:   o_ejecutar = w_v;
      CC_VC:   o_ejecutar = ~w_v;
      CC_HI:   o_ejecutar = w_c & ~w_z;
      CC_LS:   o_ejecutar = ~w_c | w_z;
      CC_GE:   o_ejecutar = (w_n == w_v);
      CC_LT:   o_ejecutar = (w_n != w_v);
      CC_GT:   o_ejecutar = ~w_z & (w_n == w_v);
      CC_LE:   o_ejecutar = w_z | (w_n != w_v);
      CC_AL:   o_ejecutar = 1'b1;
      default: o_ejecutar = 1'b0;
    endcase
  end

endmodule

// File: rtl/banderas_cond.sv
// banderas_cond: NZCV status register, condition evaluation, overflow trap
// request/acknowledge handshake and saturating overflow event counter.
// Optional macro BANDERAS_BYPASS_EN: forwards the incoming flags to the
// condition evaluator when they are being written in the same cycle.
module banderas_cond
  import banderas_pkg::*;
#(
  parameter int CONT_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flag_n,
  input  logic              i_flag_z,
  input  logic              i_flag_c,
  input  logic              i_flag_v,
  input  logic [2:0]        i_sel,
  input  logic              i_flags_we,
  input  logic [3:0]        i_cond,
  output logic              o_ejecutar,
  output logic [3:0]        o_nzcv,
  input  logic              i_trap_en,
  output logic              o_trap_req,
  input  logic              i_trap_ack,
  output logic              o_trap_perdido,
  input  logic              i_cnt_clr,
  output logic [CONT_W-1:0] o_cnt_v
);

  logic [3:0]        r_nzcv;
  logic [CONT_W-1:0] r_cnt_v;
  logic              r_perdido;
  logic              r_pend;
  trap_st_e          r_state;
  trap_st_e          w_state_next;
  logic              w_pend_next;
  logic              w_v_eff;
  logic              w_ov_evt;
  logic              w_trap_evt;
  logic [3:0]        w_flags_in;
  logic [3:0]        w_eval_flags;

  // V is only meaningful for add/sub; logic ops clear it
  assign w_v_eff    = i_flag_v & (i_sel[2:1] == SEL_ADDSUB);
  assign w_flags_in = {i_flag_n, i_flag_z, i_flag_c, w_v_eff};
  assign w_ov_evt   = i_flags_we & w_v_eff;
  assign w_trap_evt = w_ov_evt & i_trap_en;

`ifdef BANDERAS_BYPASS_EN
  assign w_eval_flags = i_flags_we ? w_flags_in : r_nzcv;
`else
  assign w_eval_flags = r_nzcv;
`endif

  evaluador_cond u_eval (
    .i_flags    (w_eval_flags),
    .i_cond     (i_cond),
    .o_ejecutar (o_ejecutar)
  );

  // Architectural flag register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)        r_nzcv <= 4'b0000;
    else if (i_flags_we) r_nzcv <= w_flags_in;
  end

  // Saturating overflow counter; clear wins over a same-cycle event
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                              r_cnt_v <= '0;
    else if (i_cnt_clr)                        r_cnt_v <= '0;
    else if (w_ov_evt && (r_cnt_v != '1))      r_cnt_v <= r_cnt_v + 1'b1;
  end

  // Sticky lost-trap flag; a new loss wins over a same-cycle clear
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                   r_perdido <= 1'b0;
    else if (w_trap_evt && (r_state != ST_IDLE))    r_perdido <= 1'b1;
    else if (i_cnt_clr)                             r_perdido <= 1'b0;
  end

  // Trap FSM state register plus a one-deep pending slot for an event that
  // arrives on the ESPERA->IDLE transition
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pend  <= w_pend_next;
    end
  end

  // Trap FSM next-state logic (4-phase req/ack)
  always_comb begin
    w_state_next = r_state;
    w_pend_next  = r_pend;
    case (r_state)
      ST_IDLE: begin
        w_pend_next = 1'b0;
        if (w_trap_evt || r_pend) w_state_next = ST_REQ;
      end
      ST_REQ: begin
        if (i_trap_ack) w_state_next = ST_ESPERA;
      end
      ST_ESPERA: begin
        if (!i_trap_ack) begin
          w_state_next = ST_IDLE;
          w_pend_next  = w_trap_evt;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign o_nzcv         = r_nzcv;
  assign o_cnt_v        = r_cnt_v;
  assign o_trap_perdido = r_perdido;
  assign o_trap_req     = (r_state == ST_REQ);

endmodule
